// File: rtl/tdr_echo_capture.sv
// Receive side of the TDR: counts time of flight from launch, timestamps synchronized echo edges,
// then streams the timestamps out. Optional echo glitch filter: define TDR_ECHO_FILTER_EN.
module tdr_echo_capture #(
    parameter int CNT_W          = 16,
    parameter int MAX_ECHOES     = 4,
    parameter int BLANK_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int FILT_CYCLES    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         launch,
    input  logic                         echo_in,
    output logic                         busy,
    output logic                         launch_drop,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             out_tof,
    output logic [$clog2(MAX_ECHOES):0]  out_idx,
    output logic                         out_last,
    output logic                         out_none,
    output logic                         timeout_flag,
    output logic [1:0]                   dbg_state
);
    localparam int IDX_W = $clog2(MAX_ECHOES) + 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(MAX_ECHOES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BLANK  = 2'd1;
    localparam logic [1:0] LISTEN = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             s1, s2, s2_d;
    logic [CNT_W-1:0] ebuf [MAX_ECHOES];
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] rd_idx;
    logic             timeout_r;

    logic             raw_edge;
    logic             accept;
    logic [CNT_W-1:0] acc_tof;
    logic [CNT_W-1:0] cnt_inc;
    logic             done_full;
    logic             done_time;
    logic [CNT_W-1:0] rd_tof;

`ifdef TDR_ECHO_FILTER_EN
    localparam int PC_W = $clog2(FILT_CYCLES + 1);
    localparam logic [PC_W-1:0] FILT_LAST = PC_W'(FILT_CYCLES - 1);

    logic             pend, pend_n;
    logic [PC_W-1:0]  pend_cnt, pend_cnt_n;
    logic [CNT_W-1:0] pend_tof, pend_tof_n;
`endif

    always_comb begin
        raw_edge = s2 & ~s2_d;
        cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
        accept   = 1'b0;
        acc_tof  = cnt;
`ifdef TDR_ECHO_FILTER_EN
        pend_n     = 1'b0;
        pend_cnt_n = pend_cnt;
        pend_tof_n = pend_tof;
        if (state == LISTEN) begin
            // A candidate edge keeps its own timestamp while its high width is qualified;
            // a new edge cannot arrive while one is pending because s2 must drop first.
            if (pend) begin
                if (s2 && pend_cnt == FILT_LAST) begin
                    accept  = 1'b1;
                    acc_tof = pend_tof;
                end else if (s2) begin
                    pend_n     = 1'b1;
                    pend_cnt_n = pend_cnt + 1'b1;
                end
            end else if (raw_edge && cnt <= TIMEOUT_C) begin
                if (FILT_CYCLES <= 1) begin
                    accept = 1'b1;
                end else begin
                    pend_n     = 1'b1;
                    pend_cnt_n = PC_W'(1);
                    pend_tof_n = cnt;
                end
            end
        end
        done_time = (cnt >= TIMEOUT_C) && !pend_n;
`else
        accept    = (state == LISTEN) && raw_edge;
        done_time = (cnt == TIMEOUT_C);
`endif
        done_full = accept && (count + 1'b1 == IDX_MAX);
    end

    always_comb begin
        rd_tof = '0;
        for (int i = 0; i < MAX_ECHOES; i++) begin
            if (rd_idx == IDX_W'(i)) rd_tof = ebuf[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s2_d      <= 1'b0;
            count     <= '0;
            rd_idx    <= '0;
            timeout_r <= 1'b0;
            for (int i = 0; i < MAX_ECHOES; i++) ebuf[i] <= '0;
        end else begin
            s1   <= echo_in;
            s2   <= s1;
            s2_d <= s2;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= BLANK;
                        cnt       <= '0;
                        count     <= '0;
                        rd_idx    <= '0;
                        timeout_r <= 1'b0;
                        s2_d      <= 1'b0;
                    end
                end
                BLANK: begin
                    cnt <= cnt_inc;
                    if (cnt == BLANK_LAST) state <= LISTEN;
                end
                LISTEN: begin
                    cnt <= cnt_inc;
                    if (accept) begin
                        for (int i = 0; i < MAX_ECHOES; i++) begin
                            if (count == IDX_W'(i)) ebuf[i] <= acc_tof;
                        end
                        count <= count + 1'b1;
                    end
                    // A filling edge names the window "full" even on the timeout cycle.
                    if (done_full) begin
                        state     <= DRAIN;
                        timeout_r <= 1'b0;
                    end else if (done_time) begin
                        state     <= DRAIN;
                        timeout_r <= 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (out_last) state <= IDLE;
                        else          rd_idx <= rd_idx + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef TDR_ECHO_FILTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_cnt <= '0;
            pend_tof <= '0;
        end else begin
            pend     <= pend_n;
            pend_cnt <= pend_cnt_n;
            pend_tof <= pend_tof_n;
        end
    end
`endif

    // Handshake: a beat transfers on a cycle with out_valid & out_ready; while out_valid is high
    // and out_ready low, every out_* field holds its value.
    assign busy         = (state != IDLE);
    assign launch_drop  = launch && busy;
    assign out_valid    = (state == DRAIN);
    assign out_none     = out_valid && (count == '0);
    assign out_tof      = (out_valid && !out_none) ? rd_tof : '0;
    assign out_idx      = out_valid ? rd_idx : '0;
    assign out_last     = out_valid && (out_none || rd_idx == count - 1'b1);
    assign timeout_flag = out_valid && timeout_r;
    assign dbg_state    = state;
endmodule

// File: tb/tb_tdr_echo_capture.sv
// Bench for tdr_echo_capture: table of echo scenarios, scoreboard of expected output beats,
// plus hand-written backpressure and mid-measurement reset sequences.
module tb_tdr_echo_capture;
    localparam int TIMEOUT = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        launch = 1'b0;
    logic        echo_in = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, launch_drop, out_valid, out_last, out_none, timeout_flag;
    logic [15:0] out_tof;
    logic [2:0]  out_idx;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // beat = {tof, idx, last, none, timeout}
    logic [21:0] exp_q[$];
    logic [21:0] mon_got, mon_want;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][15:0] st;
        logic [3:0][15:0] wd;
        logic [2:0]       exp_n;
        logic [3:0][15:0] exp_tof;
        logic             exp_to;
    } vec_t;

    vec_t vecs[$];

    tdr_echo_capture dut (
        .clk(clk), .rst(rst), .launch(launch), .echo_in(echo_in),
        .busy(busy), .launch_drop(launch_drop), .out_valid(out_valid), .out_ready(out_ready),
        .out_tof(out_tof), .out_idx(out_idx), .out_last(out_last), .out_none(out_none),
        .timeout_flag(timeout_flag), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic vec_t mk(input int n, input int s0, input int w0, input int s1, input int w1,
                                input int s2, input int w2, input int s3, input int w3,
                                input int en, input int t0, input int t1, input int t2, input int t3,
                                input bit to);
        vec_t v;
        v.n = 3'(n);
        v.st[0] = 16'(s0); v.wd[0] = 16'(w0);
        v.st[1] = 16'(s1); v.wd[1] = 16'(w1);
        v.st[2] = 16'(s2); v.wd[2] = 16'(w2);
        v.st[3] = 16'(s3); v.wd[3] = 16'(w3);
        v.exp_n = 3'(en);
        v.exp_tof[0] = 16'(t0); v.exp_tof[1] = 16'(t1);
        v.exp_tof[2] = 16'(t2); v.exp_tof[3] = 16'(t3);
        v.exp_to = to;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        if (v.exp_n == 0) begin
            exp_q.push_back({16'd0, 3'd0, 1'b1, 1'b1, v.exp_to});
        end else begin
            for (int i = 0; i < int'(v.exp_n); i++)
                exp_q.push_back({v.exp_tof[i], 3'(i), (i == int'(v.exp_n) - 1), 1'b0, v.exp_to});
        end
    endtask

    // Launch, then drive echo pulses edge by edge until the result stream starts.
    task automatic run_vec(input vec_t v, output int end_e);
        logic lv;
        @(posedge clk); #1 launch = 1'b1;
        chk("launch_drop_idle", launch_drop, 1'b0);
        @(posedge clk); #1 launch = 1'b0;
        end_e = -1;
        for (int e = 1; e <= TIMEOUT + 10; e++) begin
            lv = 1'b0;
            for (int k = 0; k < 4; k++)
                if (k < int'(v.n) && e >= int'(v.st[k]) && e < int'(v.st[k]) + int'(v.wd[k])) lv = 1'b1;
            echo_in = lv;
            @(posedge clk); #1;
            if (out_valid) begin
                end_e = e;
                break;
            end
        end
        echo_in = 1'b0;
        chk("drain_reached", (end_e >= 0), 1'b1);
        if (v.exp_to) chk("drain_after_timeout", (end_e >= TIMEOUT), 1'b1);
        else          chk("drain_before_timeout", (end_e >= 0 && end_e < TIMEOUT), 1'b1);
    endtask

    task automatic finish_vec();
        for (int c = 0; c < 60; c++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk("drain_done", busy, 1'b0);
        chk("out_valid_dropped", out_valid, 1'b0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    // scoreboard monitor: sampled on the falling edge, between input updates and the active edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = {out_tof, out_idx, out_last, out_none, timeout_flag};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got tof=%0d idx=%0d last=%0b none=%0b to=%0b want no beat",
                         out_tof, out_idx, out_last, out_none, timeout_flag);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    errors++;
                    $display("FAIL beat got tof=%0d idx=%0d last=%0b none=%0b to=%0b want tof=%0d idx=%0d last=%0b none=%0b to=%0b",
                             mon_got[21:6], mon_got[5:3], mon_got[2], mon_got[1], mon_got[0],
                             mon_want[21:6], mon_want[5:3], mon_want[2], mon_want[1], mon_want[0]);
                end
            end
        end
    end

    initial begin
        int   end_e;
        vec_t bp;

        vecs.push_back(mk(1, 100, 10, 0, 0, 0, 0, 0, 0,     1, 101, 0, 0, 0,      1'b1));
        vecs.push_back(mk(4, 20, 5, 40, 5, 60, 5, 80, 5,    4, 21, 41, 61, 81,    1'b0));
        vecs.push_back(mk(1, 2, 3, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        1'b1));
        vecs.push_back(mk(1, 5, 20, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,        1'b1));
        vecs.push_back(mk(2, 6, 3, 30, 3, 0, 0, 0, 0,       1, 31, 0, 0, 0,       1'b1));
        vecs.push_back(mk(1, 7, 3, 0, 0, 0, 0, 0, 0,        1, 8, 0, 0, 0,        1'b1));
        vecs.push_back(mk(1, 3999, 3, 0, 0, 0, 0, 0, 0,     1, 4000, 0, 0, 0,     1'b1));
        vecs.push_back(mk(1, 4000, 3, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,        1'b1));
        vecs.push_back(mk(2, 500, 4, 1000, 4, 0, 0, 0, 0,   2, 501, 1001, 0, 0,   1'b1));
`ifdef TDR_ECHO_FILTER_EN
        vecs.push_back(mk(2, 30, 2, 50, 6, 0, 0, 0, 0,      1, 51, 0, 0, 0,       1'b1));
`else
        vecs.push_back(mk(2, 20, 1, 22, 1, 0, 0, 0, 0,      2, 21, 23, 0, 0,      1'b1));
`endif

        // reset state
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_tof", out_tof, 16'd0);
        chk("rst_timeout_flag", timeout_flag, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            push_exp(vecs[i]);
            run_vec(vecs[i], end_e);
            finish_vec();
        end

        // backpressure with a dropped launch during the drain
        bp = mk(2, 20, 3, 40, 3, 0, 0, 0, 0, 2, 21, 41, 0, 0, 1'b1);
        out_ready = 1'b0;
        push_exp(bp);
        run_vec(bp, end_e);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid_held", out_valid, 1'b1);
            chk("bp_tof_stable", out_tof, 16'd21);
            chk("bp_idx_stable", out_idx, 3'd0);
            if (c == 2) begin
                launch = 1'b1;
                #1 chk("bp_launch_drop", launch_drop, 1'b1);
            end
            @(posedge clk); #1 launch = 1'b0;
        end
        chk("bp_launch_drop_clear", launch_drop, 1'b0);
        chk("bp_still_busy", busy, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_beat1_tof", out_tof, 16'd41);
            chk("bp_beat1_last", out_last, 1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        finish_vec();

        // reset in the middle of LISTEN, after one echo was already captured
        @(posedge clk); #1 launch = 1'b1;
        @(posedge clk); #1 launch = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            echo_in = (e >= 20 && e < 23);
            @(posedge clk); #1;
        end
        chk("pre_reset_listen", dbg_state, 2'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_none", out_none, 1'b0);
        chk("mid_rst_state", dbg_state, 2'd0);
        @(posedge clk); #1 rst = 1'b0;
        bp = mk(1, 30, 3, 0, 0, 0, 0, 0, 0, 1, 31, 0, 0, 0, 1'b1);
        push_exp(bp);
        run_vec(bp, end_e);
        finish_vec();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
